// File: rtl/xbar_output_scheduler_if.sv
// Request/grant bundle between the input buffers, the output buffers and the
// per-output crossbar scheduler.
interface xbar_output_scheduler_if;
  logic [3:0]      req_valid;
  logic [3:0][1:0] req_port;
  logic [3:0]      ob_ready;
  logic [3:0]      grant;
  logic [3:0][1:0] out_sel;
  logic [3:0]      out_valid;

  modport master (
    output req_valid, req_port, ob_ready,
    input  grant, out_sel, out_valid
  );

  modport slave (
    input  req_valid, req_port, ob_ready,
    output grant, out_sel, out_valid
  );
endinterface

// File: rtl/xbar_output_scheduler.sv
// Per-output round-robin crossbar scheduler with starvation aging and a
// saturating contention counter. Grants are combinational from current state.
module xbar_output_scheduler #(
  parameter int MAX_WAIT = 7,
  parameter int CNT_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  xbar_output_scheduler_if.slave    bus,
  input  logic                      clear_stats,
  output logic [3:0]                starved,
  output logic [CNT_W-1:0]          conflict_cnt
);

  logic [1:0]      ptr      [4];
  logic [3:0]      wait_cnt [4];
  logic [3:0]      starved_r;

  logic [3:0]      grant_c;
  logic [3:0][1:0] sel_c;
  logic [3:0]      valid_c;
  logic            any_conflict;
  logic [3:0]      cand;
  logic [3:0]      cand_st;
  logic [1:0]      win;

  // First set bit of mask, scanning upward from start with wrap.
  function automatic logic [1:0] pick_first(input logic [3:0] mask,
                                            input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] sel;
    found = 1'b0;
    sel   = start;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && mask[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) starved_r[i] = (wait_cnt[i] == 4'(MAX_WAIT));
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    grant_c      = '0;
    sel_c        = '0;
    valid_c      = '0;
    any_conflict = 1'b0;
    cand         = '0;
    cand_st      = '0;
    win          = '0;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++)
        cand[i] = bus.req_valid[i] && (bus.req_port[i] == 2'(o));
      cand_st = cand & starved_r;
      win = (|cand_st) ? pick_first(cand_st, ptr[o]) : pick_first(cand, ptr[o]);
      // Two or more requesters: clearing the lowest set bit leaves something.
      if ((cand & (cand - 4'd1)) != 4'd0) any_conflict = 1'b1;
      if (bus.ob_ready[o] && (|cand)) begin
        valid_c[o]   = 1'b1;
        sel_c[o]     = win;
        grant_c[win] = 1'b1;
      end
    end
  end

  assign bus.grant     = reset ? 4'd0 : grant_c;
  assign bus.out_sel   = reset ? '0   : sel_c;
  assign bus.out_valid = reset ? 4'd0 : valid_c;
  assign starved       = reset ? 4'd0 : starved_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        ptr[i]      <= 2'd0;
        wait_cnt[i] <= 4'd0;
      end
      conflict_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int o = 0; o < 4; o++)
        if (valid_c[o]) ptr[o] <= sel_c[o] + 2'd1;
      for (int i = 0; i < 4; i++) begin
        if (grant_c[i] || !bus.req_valid[i])    wait_cnt[i] <= 4'd0;
        else if (wait_cnt[i] != 4'(MAX_WAIT))   wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
      if (clear_stats)                           conflict_cnt <= '0;
      else if (any_conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_output_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based reference model of the scheduling rules.
module tb_xbar_output_scheduler;
  localparam int MAX_WAIT = 7;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            clear_stats = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [3:0]      ob_ready  = '0;
  logic [3:0][1:0] req_port  = '0;
  logic [3:0]      starved0, starved2;
  logic [15:0]     cnt0;
  logic [1:0]      cnt2;

  int passes = 0;
  int checks = 0;

  // Reference model state
  int ptr_m [4];
  int wait_m [4];
  int cnt_m, cnt2_m;
  logic [3:0]      exp_grant, exp_valid, exp_starved;
  logic [3:0][1:0] exp_sel;
  bit              exp_conflict;

  xbar_output_scheduler_if bus0 ();
  xbar_output_scheduler_if bus2 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_port  = req_port;
  assign bus0.ob_ready  = ob_ready;
  assign bus2.req_valid = req_valid;
  assign bus2.req_port  = req_port;
  assign bus2.ob_ready  = ob_ready;

  xbar_output_scheduler #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus0),
    .clear_stats(clear_stats), .starved(starved0), .conflict_cnt(cnt0)
  );

  xbar_output_scheduler #(.MAX_WAIT(MAX_WAIT), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .bus(bus2),
    .clear_stats(clear_stats), .starved(starved2), .conflict_cnt(cnt2)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ptr_m[i]  = 0;
      wait_m[i] = 0;
    end
    cnt_m  = 0;
    cnt2_m = 0;
  endtask

  // Expected combinational outputs from model state and current inputs.
  task automatic model_eval();
    int order[$];
    int w;
    exp_grant = '0; exp_valid = '0; exp_sel = '0; exp_conflict = 0;
    for (int i = 0; i < 4; i++) exp_starved[i] = (wait_m[i] == MAX_WAIT);
    for (int o = 0; o < 4; o++) begin
      order = {};
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (ptr_m[o] + k) % 4;
        if (req_valid[i] && req_port[i] == 2'(o)) order.push_back(i);
      end
      if (order.size() >= 2) exp_conflict = 1;
      if (ob_ready[o] && order.size() > 0) begin
        w = -1;
        for (int j = 0; j < order.size(); j++)
          if (w < 0 && wait_m[order[j]] == MAX_WAIT) w = order[j];
        if (w < 0) w = order[0];
        exp_valid[o] = 1'b1;
        exp_sel[o]   = 2'(w);
        exp_grant[w] = 1'b1;
      end
    end
  endtask

  // Edge update of the model, using the values from model_eval.
  task automatic model_commit();
    for (int o = 0; o < 4; o++)
      if (exp_valid[o]) ptr_m[o] = (int'(exp_sel[o]) + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (exp_grant[i] || !req_valid[i]) wait_m[i] = 0;
      else if (wait_m[i] < MAX_WAIT)     wait_m[i] = wait_m[i] + 1;
    end
    if (clear_stats) begin
      cnt_m = 0; cnt2_m = 0;
    end else if (exp_conflict) begin
      if (cnt_m < 65535) cnt_m++;
      if (cnt2_m < 3)    cnt2_m++;
    end
  endtask

  task automatic end_cycle();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = 4'hF; ob_ready = 4'hF;
    for (int i = 0; i < 4; i++) req_port[i] = 2'd1;
    repeat (2) @(negedge clock);
    checks++; if (bus0.grant !== 4'd0) $display("FAIL reset_grant got=%b exp=0000", bus0.grant); else passes++;
    checks++; if (bus0.out_valid !== 4'd0) $display("FAIL reset_out_valid got=%b exp=0000", bus0.out_valid); else passes++;
    checks++; if (bus0.out_sel !== 8'd0) $display("FAIL reset_out_sel got=%h exp=00", bus0.out_sel); else passes++;
    checks++; if (cnt0 !== 16'd0) $display("FAIL reset_conflict_cnt got=%0d exp=0", cnt0); else passes++;
    checks++; if (starved0 !== 4'd0) $display("FAIL reset_starved got=%b exp=0000", starved0); else passes++;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    model_eval();
    checks++; if (bus0.grant !== 4'b0001) $display("FAIL reset_first_grant got=%b exp=0001", bus0.grant); else passes++;
    checks++; if (bus0.out_sel[1] !== 2'd0) $display("FAIL reset_first_sel got=%0d exp=0", bus0.out_sel[1]); else passes++;
    end_cycle();
  endtask

  task automatic test_full_contention();
    do_reset();
    req_valid = 4'hF; ob_ready = 4'hF; clear_stats = 1'b0;
    for (int i = 0; i < 4; i++) req_port[i] = 2'd2;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      model_eval();
      checks++; if (bus0.grant !== (4'b0001 << (c % 4))) $display("FAIL full_grant cyc=%0d got=%b exp=%b", c, bus0.grant, 4'b0001 << (c % 4)); else passes++;
      checks++; if (bus0.out_sel[2] !== 2'(c % 4)) $display("FAIL full_sel cyc=%0d got=%0d exp=%0d", c, bus0.out_sel[2], c % 4); else passes++;
      checks++; if (bus0.out_valid !== 4'b0100) $display("FAIL full_valid cyc=%0d got=%b exp=0100", c, bus0.out_valid); else passes++;
      end_cycle();
    end
    checks++; if (cnt0 !== 16'd8) $display("FAIL full_conflict_cnt got=%0d exp=8", cnt0); else passes++;
  endtask

  task automatic test_permutation();
    int pre;
    req_valid = 4'hF; ob_ready = 4'hF;
    req_port[0] = 2'd3; req_port[1] = 2'd2; req_port[2] = 2'd1; req_port[3] = 2'd0;
    pre = cnt_m;
    @(negedge clock);
    model_eval();
    checks++; if (bus0.grant !== 4'hF) $display("FAIL perm_grant got=%b exp=1111", bus0.grant); else passes++;
    checks++; if (bus0.out_sel !== {2'd0, 2'd1, 2'd2, 2'd3}) $display("FAIL perm_sel got=%h exp=1b", bus0.out_sel); else passes++;
    end_cycle();
    checks++; if (cnt0 !== 16'(pre)) $display("FAIL perm_conflict_cnt got=%0d exp=%0d", cnt0, pre); else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b1000; ob_ready = 4'b1110;
    for (int i = 0; i < 4; i++) req_port[i] = 2'd0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      model_eval();
      checks++; if (bus0.grant !== 4'd0) $display("FAIL bp_hold_grant cyc=%0d got=%b exp=0000", c, bus0.grant); else passes++;
      end_cycle();
    end
    checks++; if (starved0 !== 4'b1000) $display("FAIL bp_starved got=%b exp=1000", starved0); else passes++;
    req_valid = 4'b1001; ob_ready = 4'hF;
    @(negedge clock);
    model_eval();
    checks++; if (bus0.grant !== 4'b1000) $display("FAIL bp_starved_grant got=%b exp=1000", bus0.grant); else passes++;
    checks++; if (bus0.out_sel[0] !== 2'd3) $display("FAIL bp_starved_sel got=%0d exp=3", bus0.out_sel[0]); else passes++;
    end_cycle();
    @(negedge clock);
    model_eval();
    checks++; if (bus0.grant !== 4'b0001) $display("FAIL bp_next_grant got=%b exp=0001", bus0.grant); else passes++;
    checks++; if (starved0 !== 4'd0) $display("FAIL bp_starved_cleared got=%b exp=0000", starved0); else passes++;
    end_cycle();
  endtask

  task automatic test_stats();
    do_reset();
    req_valid = 4'hF; ob_ready = 4'hF;
    for (int i = 0; i < 4; i++) req_port[i] = 2'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); model_eval(); end_cycle();
    end
    checks++; if (cnt0 !== 16'd3) $display("FAIL stats_pre_clear got=%0d exp=3", cnt0); else passes++;
    clear_stats = 1'b1;
    @(negedge clock); model_eval(); end_cycle();
    clear_stats = 1'b0;
    checks++; if (cnt0 !== 16'd0) $display("FAIL stats_clear got=%0d exp=0", cnt0); else passes++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); model_eval(); end_cycle();
    end
    checks++; if (cnt2 !== 2'd3) $display("FAIL stats_saturate got=%0d exp=3", cnt2); else passes++;
    checks++; if (cnt0 !== 16'd5) $display("FAIL stats_wide_count got=%0d exp=5", cnt0); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'hF; ob_ready = 4'hF;
    for (int i = 0; i < 4; i++) req_port[i] = 2'd2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock); model_eval(); end_cycle();
    end
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checks++; if (bus0.grant !== 4'd0) $display("FAIL mid_reset_grant got=%b exp=0000", bus0.grant); else passes++;
    checks++; if (bus0.out_valid !== 4'd0) $display("FAIL mid_reset_valid got=%b exp=0000", bus0.out_valid); else passes++;
    checks++; if (cnt0 !== 16'd0) $display("FAIL mid_reset_cnt got=%0d exp=0", cnt0); else passes++;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      model_eval();
      checks++; if (bus0.grant !== (4'b0001 << c)) $display("FAIL mid_restart_grant cyc=%0d got=%b exp=%b", c, bus0.grant, 4'b0001 << c); else passes++;
      end_cycle();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // Long stretches of low readiness let wait counters reach the threshold.
      req_valid   = 4'($urandom_range(0, 15));
      ob_ready    = ((c / 40) % 2 == 1) ? 4'($urandom_range(0, 15) & $urandom_range(0, 15)) : 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      for (int i = 0; i < 4; i++) req_port[i] = 2'($urandom_range(0, 3));
      clear_stats = ($urandom_range(0, 49) == 0);
      @(negedge clock);
      model_eval();
      checks++; if (bus0.grant !== exp_grant) $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, bus0.grant, exp_grant); else passes++;
      checks++; if (bus0.out_sel !== exp_sel) $display("FAIL rand_sel cyc=%0d got=%h exp=%h", c, bus0.out_sel, exp_sel); else passes++;
      checks++; if (bus0.out_valid !== exp_valid) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus0.out_valid, exp_valid); else passes++;
      checks++; if (starved0 !== exp_starved) $display("FAIL rand_starved cyc=%0d got=%b exp=%b", c, starved0, exp_starved); else passes++;
      checks++; if (cnt0 !== 16'(cnt_m)) $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, cnt0, cnt_m); else passes++;
      checks++; if (cnt2 !== 2'(cnt2_m)) $display("FAIL rand_cnt_sat cyc=%0d got=%0d exp=%0d", c, cnt2, cnt2_m); else passes++;
      end_cycle();
    end
    clear_stats = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_contention();
    test_permutation();
    test_backpressure();
    test_stats();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
